// File: rtl/serial_master_port.sv
// serial_master_port: bit-serial bus master. Each transaction shifts an address
// MSB-first (slave-select ID bits, then the rest), then one or more data beats
// written on wr_bus or read from rd_bus, with a valid/ready handshake per bit.
// Optional feature: define SERIAL_MASTER_PORT_TIMEOUT_EN to abort a transaction
// with m_err after TIMEOUT_CYC consecutive stalled cycles.
module serial_master_port #(
  parameter int ADDR_W      = 16,
  parameter int ID_W        = 4,
  parameter int DATA_W      = 8,
  parameter int LEN_W       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rstn,
  output logic              mode,
  output logic              wr_bus,
  input  logic              rd_bus,
  input  logic              ack,
  output logic              master_valid,
  input  logic              slave_ready,
  output logic              master_ready,
  input  logic              slave_valid,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic              m_mode,
  input  logic [LEN_W-1:0]  m_len,
  input  logic [DATA_W-1:0] m_wr_data,
  input  logic              m_start,
  output logic [DATA_W-1:0] m_rd_data,
  output logic              m_rd_valid,
  output logic              m_wr_req,
  output logic              m_done,
  output logic              m_err,
  output logic              m_busy
);

  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR_ID   = 3'd1,
    ADDR_REST = 3'd2,
    WR_DATA   = 3'd3,
    RD_DATA   = 3'd4,
    NEXT      = 3'd5,
    DONE      = 3'd6,
    ERR       = 3'd7
  } state_t;

  state_t              state_r, next_state_s;
  logic [ADDR_W-1:0]   addr_sh_r;
  logic [DATA_W-1:0]   data_sh_r;
  logic [DATA_W-2:0]   rd_sh_r;
  logic [DATA_W-1:0]   rd_next_s;
  logic [CNT_W-1:0]    bit_cnt_r;
  logic [LEN_W-1:0]    beat_cnt_r;
  logic [LEN_W-1:0]    len_r;
  logic                mode_r;
  logic [DATA_W-1:0]   rd_data_r;
  logic                rd_valid_r;
  logic                wr_xfer_s, rd_xfer_s;
  logic                last_id_s, last_addr_s, last_data_s, last_beat_s;
  logic                timeout_s;

  assign wr_xfer_s   = master_valid & slave_ready;
  assign rd_xfer_s   = master_ready & slave_valid;
  assign last_id_s   = (bit_cnt_r == CNT_W'(ID_W - 1));
  assign last_addr_s = (bit_cnt_r == CNT_W'(ADDR_W - 1));
  assign last_data_s = (bit_cnt_r == CNT_W'(DATA_W - 1));
  // Beat counter stops at len_r, so m_len all-ones never needs to wrap.
  assign last_beat_s = (beat_cnt_r == len_r);
  assign rd_next_s   = {rd_sh_r, rd_bus};
  assign mode        = mode_r;
  assign m_rd_data   = rd_data_r;
  assign m_rd_valid  = rd_valid_r;

`ifdef SERIAL_MASTER_PORT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] stall_cnt_r;
  logic            stall_s;

  assign stall_s   = (master_valid & ~slave_ready) | (master_ready & ~slave_valid);
  assign timeout_s = stall_s && (stall_cnt_r == TO_W'(TIMEOUT_CYC - 1));

  // Count consecutive stalled handshake cycles; any non-stalled cycle restarts it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_cnt_r <= '0;
    end else if (stall_s) begin
      stall_cnt_r <= stall_cnt_r + TO_W'(1);
    end else begin
      stall_cnt_r <= '0;
    end
  end
`else
  // No stall supervision: the master waits on the slave indefinitely.
  assign timeout_s = (TIMEOUT_CYC < 0);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decision from handshakes, bit/beat counters and ack.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (m_start) next_state_s = ADDR_ID;
        else         next_state_s = IDLE;
      end
      ADDR_ID: begin
        if (timeout_s)                    next_state_s = ERR;
        else if (wr_xfer_s && last_id_s)  next_state_s = ack ? ADDR_REST : ERR;
        else                              next_state_s = ADDR_ID;
      end
      ADDR_REST: begin
        if (timeout_s)                     next_state_s = ERR;
        else if (wr_xfer_s && last_addr_s) next_state_s = mode_r ? WR_DATA : RD_DATA;
        else                               next_state_s = ADDR_REST;
      end
      WR_DATA: begin
        if (timeout_s)                     next_state_s = ERR;
        else if (wr_xfer_s && last_data_s) next_state_s = last_beat_s ? DONE : NEXT;
        else                               next_state_s = WR_DATA;
      end
      RD_DATA: begin
        if (timeout_s)                     next_state_s = ERR;
        else if (rd_xfer_s && last_data_s) next_state_s = last_beat_s ? DONE : NEXT;
        else                               next_state_s = RD_DATA;
      end
      NEXT:    next_state_s = mode_r ? WR_DATA : RD_DATA;
      DONE:    next_state_s = IDLE;
      ERR:     next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Bus-side and host-side strobes decoded from the current state.
  always_comb begin
    master_valid = 1'b0;
    master_ready = 1'b0;
    wr_bus       = 1'b0;
    m_wr_req     = 1'b0;
    m_done       = 1'b0;
    m_err        = 1'b0;
    m_busy       = (state_r != IDLE);
    case (state_r)
      ADDR_ID, ADDR_REST: begin
        master_valid = 1'b1;
        wr_bus       = addr_sh_r[ADDR_W-1];
      end
      WR_DATA: begin
        master_valid = 1'b1;
        wr_bus       = data_sh_r[DATA_W-1];
      end
      RD_DATA: master_ready = 1'b1;
      NEXT:    m_wr_req     = mode_r;
      DONE:    m_done       = 1'b1;
      ERR:     m_err        = 1'b1;
      default: m_busy       = (state_r != IDLE);
    endcase
  end

  // Datapath: request latching, shift registers, counters and read-data capture.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_sh_r  <= '0;
      data_sh_r  <= '0;
      rd_sh_r    <= '0;
      bit_cnt_r  <= '0;
      beat_cnt_r <= '0;
      len_r      <= '0;
      mode_r     <= 1'b0;
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (m_start) begin
            addr_sh_r  <= m_addr;
            data_sh_r  <= m_wr_data;
            mode_r     <= m_mode;
            len_r      <= m_len;
            bit_cnt_r  <= '0;
            beat_cnt_r <= '0;
          end
        end
        ADDR_ID, ADDR_REST: begin
          if (wr_xfer_s) begin
            addr_sh_r <= {addr_sh_r[ADDR_W-2:0], 1'b0};
            bit_cnt_r <= (state_r == ADDR_REST && last_addr_s) ? '0 : bit_cnt_r + CNT_W'(1);
          end
        end
        WR_DATA: begin
          if (wr_xfer_s) begin
            data_sh_r <= {data_sh_r[DATA_W-2:0], 1'b0};
            bit_cnt_r <= last_data_s ? '0 : bit_cnt_r + CNT_W'(1);
          end
        end
        RD_DATA: begin
          if (rd_xfer_s) begin
            rd_sh_r   <= rd_next_s[DATA_W-2:0];
            bit_cnt_r <= last_data_s ? '0 : bit_cnt_r + CNT_W'(1);
            if (last_data_s) begin
              rd_data_r  <= rd_next_s;
              rd_valid_r <= 1'b1;
            end
          end
        end
        NEXT: begin
          beat_cnt_r <= beat_cnt_r + LEN_W'(1);
          if (mode_r) data_sh_r <= m_wr_data;
        end
        DONE, ERR: begin
          addr_sh_r  <= '0;
          data_sh_r  <= '0;
          rd_sh_r    <= '0;
          bit_cnt_r  <= '0;
          beat_cnt_r <= '0;
          len_r      <= '0;
        end
        default: rd_valid_r <= 1'b0;
      endcase
    end
  end

endmodule
